// File: rtl/sextium_w_pkg.sv
// rtl/sextium_w_pkg.sv - shared opcodes, FSM encoding and SYSCALL codes for the Sextium core
package sextium_w_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_SYSCALL = 4'd1;
  localparam logic [3:0] OP_LOAD    = 4'd2;
  localparam logic [3:0] OP_STORE   = 4'd3;
  localparam logic [3:0] OP_SWAPA   = 4'd4;
  localparam logic [3:0] OP_SWAPD   = 4'd5;
  localparam logic [3:0] OP_BRANCHZ = 4'd6;
  localparam logic [3:0] OP_BRANCHN = 4'd7;
  localparam logic [3:0] OP_JUMP    = 4'd8;
  localparam logic [3:0] OP_CONST   = 4'd9;
  localparam logic [3:0] OP_ADD     = 4'd10;
  localparam logic [3:0] OP_SUB     = 4'd11;
  localparam logic [3:0] OP_MUL     = 4'd12;
  localparam logic [3:0] OP_AND     = 4'd13;
  localparam logic [3:0] OP_XOR     = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MEMW  = 3'd2;
  localparam logic [2:0] ST_IOW   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam int SYS_HALT  = 0;
  localparam int SYS_READ  = 1;
  localparam int SYS_WRITE = 2;

endpackage

// File: rtl/sextium_core_w_alu.sv
// rtl/sextium_core_w_alu.sv - combinational acc-op-dr unit for opcodes 10..14
module sextium_alu_w
  import sextium_w_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Results keep only the low W bits; overflow wraps.
  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/sextium_core_w.sv
// rtl/sextium_core_w.sv - Sextium accumulator core: 4-bit slot decode, memory/IO handshakes, halt
module sextium_core_w
  import sextium_w_pkg::*;
#(
  parameter int W = 16,
  localparam int SLOTS = W / 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] mem_bus_in,
  input  logic         mem_ack,
  input  logic [W-1:0] io_bus_in,
  input  logic         ioack,
  output logic [W-1:0] addr_bus,
  output logic [W-1:0] mem_bus_out,
  output logic [W-1:0] io_bus_out,
  output logic         mem_read,
  output logic         mem_write,
  output logic         io_read,
  output logic         io_write,
  output logic         halted,
  output logic [3:0]   insn
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  logic [W-1:0]  acc_q, acc_d, ar_q, ar_d, dr_q, dr_d, ir_q, ir_d, pc_q, pc_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    state_q, state_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic          io_read_q, io_read_d, io_write_q, io_write_d;
  logic [3:0]    op;
  logic [W-1:0]  alu_y;
  logic          done, redirect, acked;

  // Slot 0 is the top nibble of ir.
  assign op = 4'(ir_q >> {LAST_SLOT - slot_q, 2'b00});

  sextium_alu_w #(.W(W)) u_alu (
    .op (op),
    .a  (acc_q),
    .b  (dr_q),
    .y  (alu_y)
  );

  always_comb begin
    acc_d    = acc_q;
    ar_d     = ar_q;
    dr_d     = dr_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    slot_d   = slot_q;
    state_d  = state_q;
    done     = 1'b0;
    redirect = 1'b0;
    acked    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (mem_read_q && mem_ack) begin
          ir_d    = mem_bus_in;
          pc_d    = pc_q + W'(1);
          slot_d  = '0;
          state_d = ST_EXEC;
          acked   = 1'b1;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_NOP: done = 1'b1;
          OP_SYSCALL: begin
            if (acc_q == W'(SYS_HALT)) state_d = ST_HALT;
            else if (acc_q == W'(SYS_READ) || acc_q == W'(SYS_WRITE)) state_d = ST_IOW;
            else done = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_CONST: state_d = ST_MEMW;
          OP_SWAPA: begin
            acc_d = ar_q;
            ar_d  = acc_q;
            done  = 1'b1;
          end
          OP_SWAPD: begin
            acc_d = dr_q;
            dr_d  = acc_q;
            done  = 1'b1;
          end
          OP_BRANCHZ: begin
            done = 1'b1;
            if (acc_q == '0) begin
              pc_d     = ar_q;
              redirect = 1'b1;
            end
          end
          OP_BRANCHN: begin
            done = 1'b1;
            if (acc_q[W-1]) begin
              pc_d     = ar_q;
              redirect = 1'b1;
            end
          end
          OP_JUMP: begin
            pc_d     = acc_q;
            redirect = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR: begin
            acc_d = alu_y;
            done  = 1'b1;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEMW: begin
        if ((mem_read_q || mem_write_q) && mem_ack) begin
          acked = 1'b1;
          done  = 1'b1;
          if (op == OP_LOAD) acc_d = mem_bus_in;
          if (op == OP_CONST) begin
            acc_d = mem_bus_in;
            pc_d  = pc_q + W'(1);
          end
        end
      end
      ST_IOW: begin
        if ((io_read_q || io_write_q) && ioack) begin
          acked = 1'b1;
          done  = 1'b1;
          if (io_read_q) acc_d = io_bus_in;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    if (done) begin
      if (redirect || slot_q == LAST_SLOT) begin
        state_d = ST_FETCH;
      end else begin
        slot_d  = slot_q + SW'(1);
        state_d = ST_EXEC;
      end
    end
  end

  // Strobes follow the next state, but always drop for one cycle after an ack.
  always_comb begin
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    io_read_d   = 1'b0;
    io_write_d  = 1'b0;
    if (!acked) begin
      case (state_d)
        ST_FETCH: mem_read_d = 1'b1;
        ST_MEMW: begin
          if (op == OP_STORE) mem_write_d = 1'b1;
          else mem_read_d = 1'b1;
        end
        ST_IOW: begin
          if (acc_q == W'(SYS_READ)) io_read_d = 1'b1;
          else io_write_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      ar_q        <= '0;
      dr_q        <= '0;
      ir_q        <= '0;
      pc_q        <= '0;
      slot_q      <= '0;
      state_q     <= ST_FETCH;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      io_read_q   <= 1'b0;
      io_write_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ar_q        <= ar_d;
      dr_q        <= dr_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      slot_q      <= slot_d;
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      io_read_q   <= io_read_d;
      io_write_q  <= io_write_d;
    end
  end

  assign addr_bus    = (state_q == ST_MEMW && op != OP_CONST) ? ar_q : pc_q;
  assign mem_bus_out = acc_q;
  assign io_bus_out  = dr_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign io_read     = io_read_q;
  assign io_write    = io_write_q;
  assign halted      = (state_q == ST_HALT);
  assign insn        = op;

endmodule

// File: tb/tb_sextium_core_w.sv
// tb/tb_sextium_core_w.sv - directed self-checking bench for sextium_core_w at W=16 and W=32
module tb_sextium_core_w;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_mem_ack, a_ioack;
  logic [15:0] a_mem_in, a_io_in, a_addr, a_mem_out, a_io_out;
  logic        a_mem_read, a_mem_write, a_io_read, a_io_write, a_halted;
  logic [3:0]  a_insn;

  logic        b_reset, b_mem_ack, b_ioack;
  logic [31:0] b_mem_in, b_io_in, b_addr, b_mem_out, b_io_out;
  logic        b_mem_read, b_mem_write, b_io_read, b_io_write, b_halted;
  logic [3:0]  b_insn;

  int checks = 0;
  int errors = 0;

  sextium_core_w #(.W(16)) dut_a (
    .clock(clock), .reset(a_reset), .mem_bus_in(a_mem_in), .mem_ack(a_mem_ack),
    .io_bus_in(a_io_in), .ioack(a_ioack), .addr_bus(a_addr), .mem_bus_out(a_mem_out),
    .io_bus_out(a_io_out), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .io_read(a_io_read), .io_write(a_io_write), .halted(a_halted), .insn(a_insn)
  );

  sextium_core_w #(.W(32)) dut_b (
    .clock(clock), .reset(b_reset), .mem_bus_in(b_mem_in), .mem_ack(b_mem_ack),
    .io_bus_in(b_io_in), .ioack(b_ioack), .addr_bus(b_addr), .mem_bus_out(b_mem_out),
    .io_bus_out(b_io_out), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .io_read(b_io_read), .io_write(b_io_write), .halted(b_halted), .insn(b_insn)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_rd();
    int n = 0;
    while (a_mem_read !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic serve_read(input string tag, input logic [15:0] exp_addr,
                            input logic [15:0] data, input int delay);
    wait_a_rd();
    chk({tag, " rd"}, a_mem_read, 1);
    chk({tag, " addr"}, a_addr, exp_addr);
    repeat (delay) begin
      @(negedge clock);
      chk({tag, " hold"}, a_mem_read, 1);
    end
    a_mem_in  = data;
    a_mem_ack = 1'b1;
    @(negedge clock);
    a_mem_ack = 1'b0;
    chk({tag, " drop"}, {a_mem_read, a_mem_write, a_io_read, a_io_write}, 0);
  endtask

  task automatic serve_io(input string tag, input bit is_read, input logic [15:0] exp_dout,
                          input logic [15:0] data, input int delay);
    int n = 0;
    while (a_io_read !== 1'b1 && a_io_write !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " strobe"}, {a_mem_read, a_io_read, a_io_write}, is_read ? 3'b010 : 3'b001);
    chk({tag, " dout"}, a_io_out, exp_dout);
    repeat (delay) begin
      @(negedge clock);
      chk({tag, " hold"}, {a_io_read, a_io_write}, is_read ? 2'b10 : 2'b01);
    end
    a_io_in = data;
    a_ioack = 1'b1;
    @(negedge clock);
    a_ioack = 1'b0;
    chk({tag, " drop"}, {a_mem_read, a_mem_write, a_io_read, a_io_write}, 0);
  endtask

  initial begin
    int n;
    a_reset = 1'b0; a_mem_ack = 1'b0; a_ioack = 1'b0; a_mem_in = '0; a_io_in = '0;
    b_reset = 1'b0; b_mem_ack = 1'b0; b_ioack = 1'b0; b_mem_in = '0; b_io_in = '0;

    // Reset held for three cycles
    repeat (3) @(negedge clock);
    chk("rst strobes", {a_mem_read, a_mem_write, a_io_read, a_io_write, a_halted}, 0);
    chk("rst addr", a_addr, 0);
    chk("rst acc", a_mem_out, 0);
    chk("rst dr", a_io_out, 0);
    chk("rst insn", a_insn, 0);
    a_reset = 1'b1;
    @(negedge clock);
    chk("first fetch rd", a_mem_read, 1);
    chk("first fetch addr", a_addr, 0);

    // CONST 3; SWAPD -> dr=3; then CONST 5; ADD -> acc=8
    serve_read("f0", 16'h0000, 16'h9500, 0);
    serve_read("c0", 16'h0001, 16'h0003, 0);
    serve_read("f1", 16'h0002, 16'h9A00, 0);
    serve_read("c1", 16'h0003, 16'h0005, 0);
    chk("add insn", a_insn, 4'hA);
    chk("acc pre add", a_mem_out, 16'h0005);
    chk("dr via swapd", a_io_out, 16'h0003);
    @(negedge clock);
    chk("acc after add", a_mem_out, 16'h0008);

    // CONST 0x100; SWAPA; LOAD with four wait states
    serve_read("f2", 16'h0004, 16'h9420, 0);
    serve_read("c2", 16'h0005, 16'h0100, 0);
    wait_a_rd();
    chk("load acc before ack", a_mem_out, 16'h0000);
    serve_read("ld", 16'h0100, 16'hBEEF, 4);
    chk("load acc after ack", a_mem_out, 16'hBEEF);

    // Set ar=0x10, acc=0, then BRANCHZ discards the ADD slots
    serve_read("f3", 16'h0006, 16'h9490, 0);
    serve_read("c3", 16'h0007, 16'h0010, 0);
    serve_read("c4", 16'h0008, 16'h0000, 0);
    serve_read("f4", 16'h0009, 16'h6AAA, 0);
    chk("branch insn", a_insn, 4'h6);
    @(negedge clock);
    chk("branch fetch rd", a_mem_read, 1);
    chk("branch target", a_addr, 16'h0010);
    chk("adds discarded", a_mem_out, 16'h0000);

    // SYSCALL write of dr, SYSCALL read into acc
    serve_read("f5", 16'h0010, 16'h9191, 0);
    serve_read("c5", 16'h0011, 16'h0002, 0);
    serve_io("io wr", 1'b0, 16'h0003, 16'h0000, 2);
    serve_read("c6", 16'h0012, 16'h0001, 0);
    serve_io("io rd", 1'b1, 16'h0003, 16'h1234, 0);
    wait_a_rd();
    chk("io read acc", a_mem_out, 16'h1234);

    // Illegal opcode halts; stray acks ignored
    serve_read("f6", 16'h0013, 16'hF000, 0);
    chk("halt insn", a_insn, 4'hF);
    @(negedge clock);
    a_mem_ack = 1'b1;
    a_ioack   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("halt quiet", {a_mem_read, a_mem_write, a_io_read, a_io_write, a_halted}, 5'b00001);
      @(negedge clock);
    end
    a_mem_ack = 1'b0;
    a_ioack   = 1'b0;

    // W=32: eight NOP slots between fetches
    b_reset = 1'b1;
    @(negedge clock);
    chk("w32 fetch addr", b_addr, 0);
    chk("w32 fetch rd", b_mem_read, 1);
    b_mem_in  = 32'h0000_0000;
    b_mem_ack = 1'b1;
    @(negedge clock);
    b_mem_ack = 1'b0;
    n = 0;
    while (b_mem_read !== 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk("w32 exec cycles", n, 8);
    chk("w32 next addr", b_addr, 32'h1);

    // Reset mid-fetch abandons the request at once
    b_reset = 1'b0;
    #1;
    chk("w32 async abort", {b_mem_read, b_addr}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
